// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encodings for the bit-serial arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_RUN  = c_st_run,
        ST_DONE = c_st_done
    } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/yAdder1.sv
// ============================================================================
// Module      : yAdder1
// Description : One-bit full-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module yAdder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic z,
    output logic cout
);

    assign z    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : yAdder1

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial W-bit adder, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z,
    output logic         cout
);

    localparam int c_cnt_w = $clog2(W);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_last;
    logic [W-1:0]         r_sa;
    logic [W-1:0]         r_sb;
    logic [W-1:0]         r_z;
    logic                 r_carry;
    logic                 r_cout;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_sum;
    logic                 w_carry_nxt;

    yAdder1 u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .z    (w_sum),
        .cout (w_carry_nxt)
    );

    assign w_last = (r_cnt == c_cnt_w'(W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start here chains straight into the next addition.
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sa    <= a;
                r_sb    <= b;
                r_carry <= cin;
                r_cnt   <= '0;
                r_z     <= '0;
            end else if (r_state == ST_RUN) begin
                r_sa    <= r_sa >> 1;
                r_sb    <= r_sb >> 1;
                r_z     <= {w_sum, r_z[W-1:1]};
                r_carry <= w_carry_nxt;
                r_cnt   <= r_cnt + c_cnt_w'(1);
                if (w_last) begin
                    r_cout <= w_carry_nxt;
                end
            end
        end
    end

    // The shift register fills during RUN; the visible sum stays 0 until DONE.
    assign z    = (r_state == ST_RUN) ? '0 : r_z;
    assign cout = r_cout;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule : serial_adder

`default_nettype wire
